// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the NOR flash read arbiter.
package flash_pkg;

    localparam int          FLASH_AW       = 22;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_WE   = 3'd1,
        CMD_DATA = 3'd2,
        CMD_END  = 3'd3,
        READ     = 3'd4,
        RECOVER  = 3'd5
    } flash_state_e;

    // The flash stores bytes opposite to the bus, so every read word is swapped.
    function automatic logic [15:0] byte_swap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Two-port round-robin arbiter: combinational grant, registered last grant.
module flash_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       valid,
    output logic       grant
);

    logic last_grant;

    // On a tie the port that did not win last time gets the flash.
    always_comb begin
        valid = req[0] | req[1];
        grant = 1'b0;
        if (req[0] && req[1]) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update && valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares a x16 NOR flash between the boot engine (port 0) and CPU reads (port 1).
// Define FLASH_CMD_CACHE_EN to skip the read-array command once it has been issued.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [15:0] CMD_WORD    = CMD_READ_ARRAY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [FLASH_AW:1]   addr0,
    output logic                ack0,
    output logic [15:0]         rdata0,
    input  logic                req1,
    input  logic [FLASH_AW:1]   addr1,
    output logic                ack1,
    output logic [15:0]         rdata1,
    output logic                flash_ce,
    output logic                flash_we,
    output logic                flash_oe,
    output logic                flash_rp,
    output logic                flash_byte,
    output logic                flash_vpen,
    output logic [FLASH_AW:1]   flash_addr,
    inout  wire  [15:0]         flash_data
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    flash_state_e state;
    logic [3:0]   cnt;
    logic         port_sel;
    logic         drive;
    logic         arb_valid;
    logic         arb_grant;
`ifdef FLASH_CMD_CACHE_EN
    logic         read_mode;
`endif

    assign flash_ce   = 1'b0;
    assign flash_rp   = 1'b1;
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_data = drive ? CMD_WORD : 16'hzzzz;

    flash_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (state == IDLE),
        .valid  (arb_valid),
        .grant  (arb_grant)
    );

    // Strobes are registered so WE, OE and the bus driver never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flash_we   <= 1'b1;
            flash_oe   <= 1'b1;
            flash_addr <= '0;
            drive      <= 1'b0;
            cnt        <= '0;
            port_sel   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef FLASH_CMD_CACHE_EN
            read_mode  <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        port_sel   <= arb_grant;
                        flash_addr <= arb_grant ? addr1 : addr0;
`ifdef FLASH_CMD_CACHE_EN
                        if (read_mode) begin
                            state    <= READ;
                            flash_oe <= 1'b0;
                            cnt      <= WAIT_LD;
                        end else begin
                            state    <= CMD_WE;
                            flash_we <= 1'b0;
                        end
`else
                        state    <= CMD_WE;
                        flash_we <= 1'b0;
`endif
                    end
                end
                CMD_WE: begin
                    state <= CMD_DATA;
                    drive <= 1'b1;
                end
                CMD_DATA: begin
                    state    <= CMD_END;
                    flash_we <= 1'b1;
                end
                CMD_END: begin
                    state    <= READ;
                    drive    <= 1'b0;
                    flash_oe <= 1'b0;
                    cnt      <= WAIT_LD;
`ifdef FLASH_CMD_CACHE_EN
                    read_mode <= 1'b1;
`endif
                end
                READ: begin
                    if (cnt == 4'd1) begin
                        state    <= RECOVER;
                        flash_oe <= 1'b1;
                        if (port_sel) begin
                            rdata1 <= byte_swap(flash_data);
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= byte_swap(flash_data);
                            ack0   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
